// File: rtl/rsa4k_stream_if.sv
// Word-stream front-end for the RSA core: loads message/exponent/modulus, pulses go, drains cypher.
// 1 cycle last-modulus-word -> go and done-edge -> m_valid; s_ready is state-only, m_ready stalls hold the word.
module rsa4k_stream_if #(
  parameter int          DATA_WIDTH     = 64,
  parameter int          RSA_WIDTH      = 4096,
  parameter int          WORDS          = 64,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  core_go,
  output logic [RSA_WIDTH-1:0]  core_message,
  output logic [RSA_WIDTH-1:0]  core_exponent,
  output logic [RSA_WIDTH-1:0]  core_modulus,
  input  logic [RSA_WIDTH-1:0]  core_cypher,
  input  logic                  core_done,
  output logic                  busy,
  output logic                  err_timeout
);

  localparam int            IW       = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [2:0] {
    ST_LOAD_M, ST_LOAD_E, ST_LOAD_N, ST_START, ST_WAIT, ST_DRAIN
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [31:0]            cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   done_q;
  logic                   rdy_en_q;
  logic [RSA_WIDTH-1:0]   msg_q, exp_q, mod_q, cyph_q;
  logic                   loading, s_fire, m_fire, last_word, done_edge, capture;

  always_comb begin
    loading   = (state_q == ST_LOAD_M) || (state_q == ST_LOAD_E) || (state_q == ST_LOAD_N);
    s_ready   = rdy_en_q && loading;
    s_fire    = s_valid && s_ready;
    m_valid   = (state_q == ST_DRAIN);
    m_fire    = m_valid && m_ready;
    last_word = (idx_q == LAST_IDX);
    // Only a rising edge counts, so a done level left over from the last operation is ignored.
    done_edge = core_done && !done_q;
    core_go   = (state_q == ST_START);
    m_last    = m_valid && last_word;
    m_data    = m_valid ? cyph_q[idx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    busy      = !((state_q == ST_LOAD_M) && (idx_q == '0));

    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    capture = 1'b0;

    case (state_q)
      ST_LOAD_M, ST_LOAD_E, ST_LOAD_N: begin
        if (s_fire) begin
          if ((state_q == ST_LOAD_M) && (idx_q == '0)) err_d = 1'b0;
          if (last_word) begin
            idx_d = '0;
            case (state_q)
              ST_LOAD_M: state_d = ST_LOAD_E;
              ST_LOAD_E: state_d = ST_LOAD_N;
              default:   state_d = ST_START;
            endcase
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_edge) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = ST_DRAIN;
        end else if (cnt_q == TIMEOUT_CYCLES - 32'd1) begin
          err_d   = 1'b1;
          idx_d   = '0;
          state_d = ST_LOAD_M;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_DRAIN: begin
        if (m_fire) begin
          if (last_word) begin
            idx_d   = '0;
            state_d = ST_LOAD_M;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        idx_d   = '0;
        state_d = ST_LOAD_M;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_LOAD_M;
      idx_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      done_q   <= core_done;
      rdy_en_q <= 1'b1;
    end
  end

  // Operands stay put after START so the core can sample them until the next load begins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg_q  <= '0;
      exp_q  <= '0;
      mod_q  <= '0;
      cyph_q <= '0;
    end else begin
      if (s_fire) begin
        case (state_q)
          ST_LOAD_M: msg_q[idx_q*DATA_WIDTH +: DATA_WIDTH] <= s_data;
          ST_LOAD_E: exp_q[idx_q*DATA_WIDTH +: DATA_WIDTH] <= s_data;
          default:   mod_q[idx_q*DATA_WIDTH +: DATA_WIDTH] <= s_data;
        endcase
      end
      if (capture) cyph_q <= core_cypher;
    end
  end

  assign core_message  = msg_q;
  assign core_exponent = exp_q;
  assign core_modulus  = mod_q;
  assign err_timeout   = err_q;

endmodule
